// File: rtl/scan_addr_gen.sv
// scan_addr_gen: raster / diagonal pixel scan address generator.
// Emits each pixel of a COLS x ROWS frame once over a valid/ready stream.
module scan_addr_gen #(
    parameter int COLS = 150,
    parameter int ROWS = 150,
    parameter int AW   = 15,
    parameter int RW   = 8
) (
    input  logic          clk,
    input  logic          resetIn,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic          abort,
    input  logic          ready,
    output logic          valid,
    output logic [AW-1:0] addr,
    output logic [RW-1:0] row,
    output logic [RW-1:0] col,
    output logic          line_first,
    output logic          line_last,
    output logic          frame_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [1:0] M_LR  = 2'd0;
    localparam logic [1:0] M_UD  = 2'd1;
    localparam logic [1:0] M_TTL = 2'd2;
    localparam logic [1:0] M_TTR = 2'd3;

    localparam logic [RW-1:0] RMAX  = RW'(ROWS - 1);
    localparam logic [RW-1:0] CMAX  = RW'(COLS - 1);
    localparam logic [RW-1:0] R1    = RW'(1);
    localparam logic [AW-1:0] CA    = AW'(COLS);
    localparam logic [AW-1:0] A1    = AW'(1);
    localparam logic [AW-1:0] ACMAX = AW'(COLS - 1);

    state_t        state, state_n;
    logic [1:0]    mode_q, mode_n;
    logic          valid_n, busy_n, done_n;
    logic [AW-1:0] addr_n;
    logic [RW-1:0] row_n, col_n;
    logic          lf_n, ll_n, fl_n;
    // Start of the current diagonal line (row, col, address)
    logic [RW-1:0] ls_row, ls_col, lsr_n, lsc_n;
    logic [AW-1:0] ls_addr, lsa_n;
    logic          fire;

    function automatic logic f_line_end(
        input logic [1:0]    m,
        input logic [RW-1:0] r,
        input logic [RW-1:0] c
    );
        logic e;
        unique case (m)
            M_LR:    e = (c == CMAX);
            M_UD:    e = (r == RMAX);
            M_TTL:   e = (r == '0) || (c == CMAX);
            default: e = (r == '0) || (c == '0);
        endcase
        return e;
    endfunction

    function automatic logic f_frame_end(
        input logic [1:0]    m,
        input logic [RW-1:0] r,
        input logic [RW-1:0] c
    );
        logic e;
        if (m == M_TTR)
            e = (r == RMAX) && (c == '0);
        else
            e = (r == RMAX) && (c == CMAX);
        return e;
    endfunction

    assign fire = valid && ready;

    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        valid_n = valid;
        busy_n  = busy;
        done_n  = 1'b0;
        addr_n  = addr;
        row_n   = row;
        col_n   = col;
        lf_n    = line_first;
        ll_n    = line_last;
        fl_n    = frame_last;
        lsr_n   = ls_row;
        lsc_n   = ls_col;
        lsa_n   = ls_addr;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = SCAN;
                    mode_n  = mode;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    row_n   = '0;
                    if (mode == M_TTR) begin
                        col_n  = CMAX;
                        addr_n = ACMAX;
                    end else begin
                        col_n  = '0;
                        addr_n = '0;
                    end
                    lsr_n = '0;
                    lsc_n = col_n;
                    lsa_n = addr_n;
                    lf_n  = 1'b1;
                    ll_n  = f_line_end(mode, row_n, col_n);
                    fl_n  = f_frame_end(mode, row_n, col_n);
                end
            end
            SCAN: begin
                if (abort) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    busy_n  = 1'b0;
                    lf_n    = 1'b0;
                    ll_n    = 1'b0;
                    fl_n    = 1'b0;
                end else if (fire && frame_last) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    lf_n    = 1'b0;
                    ll_n    = 1'b0;
                    fl_n    = 1'b0;
                end else if (fire) begin
                    // A new line begins exactly when the current beat closes one
                    lf_n = line_last;
                    unique case (mode_q)
                        M_LR: begin
                            addr_n = addr + A1;
                            if (line_last) begin
                                row_n = row + R1;
                                col_n = '0;
                            end else begin
                                col_n = col + R1;
                            end
                        end
                        M_UD: begin
                            if (line_last) begin
                                row_n  = '0;
                                col_n  = col + R1;
                                addr_n = AW'(col) + A1;
                            end else begin
                                row_n  = row + R1;
                                addr_n = addr + CA;
                            end
                        end
                        M_TTL: begin
                            if (line_last) begin
                                if (ls_row != RMAX) begin
                                    lsr_n = ls_row + R1;
                                    lsa_n = ls_addr + CA;
                                end else begin
                                    lsc_n = ls_col + R1;
                                    lsa_n = ls_addr + A1;
                                end
                                row_n  = lsr_n;
                                col_n  = lsc_n;
                                addr_n = lsa_n;
                            end else begin
                                row_n  = row - R1;
                                col_n  = col + R1;
                                addr_n = addr - CA + A1;
                            end
                        end
                        default: begin
                            if (line_last) begin
                                if (ls_row != RMAX) begin
                                    lsr_n = ls_row + R1;
                                    lsa_n = ls_addr + CA;
                                end else begin
                                    lsc_n = ls_col - R1;
                                    lsa_n = ls_addr - A1;
                                end
                                row_n  = lsr_n;
                                col_n  = lsc_n;
                                addr_n = lsa_n;
                            end else begin
                                row_n  = row - R1;
                                col_n  = col - R1;
                                addr_n = addr - CA - A1;
                            end
                        end
                    endcase
                    ll_n = f_line_end(mode_q, row_n, col_n);
                    fl_n = f_frame_end(mode_q, row_n, col_n);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetIn) begin
            state      <= IDLE;
            mode_q     <= M_LR;
            valid      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            addr       <= '0;
            row        <= '0;
            col        <= '0;
            line_first <= 1'b0;
            line_last  <= 1'b0;
            frame_last <= 1'b0;
            ls_row     <= '0;
            ls_col     <= '0;
            ls_addr    <= '0;
        end else begin
            state      <= state_n;
            mode_q     <= mode_n;
            valid      <= valid_n;
            busy       <= busy_n;
            done       <= done_n;
            addr       <= addr_n;
            row        <= row_n;
            col        <= col_n;
            line_first <= lf_n;
            line_last  <= ll_n;
            frame_last <= fl_n;
            ls_row     <= lsr_n;
            ls_col     <= lsc_n;
            ls_addr    <= lsa_n;
        end
    end

endmodule

// File: tb/tb_scan_addr_gen.sv
// tb_scan_addr_gen: 4x3 vector table for all scan orders plus
// 150x150 control sequences (ignored start, abort, reset).
module tb_scan_addr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       s_rst, s_start, s_abort, s_ready;
    logic [1:0] s_mode;
    logic       s_valid, s_lf, s_ll, s_fl, s_busy, s_done;
    logic [3:0] s_addr;
    logic [1:0] s_row, s_col;

    logic        b_rst, b_start, b_abort, b_ready;
    logic [1:0]  b_mode;
    logic        b_valid, b_lf, b_ll, b_fl, b_busy, b_done;
    logic [14:0] b_addr;
    logic [7:0]  b_row, b_col;

    scan_addr_gen #(.COLS(4), .ROWS(3), .AW(4), .RW(2)) u_s (
        .clk(clk), .resetIn(s_rst), .start(s_start), .mode(s_mode),
        .abort(s_abort), .ready(s_ready), .valid(s_valid),
        .addr(s_addr), .row(s_row), .col(s_col),
        .line_first(s_lf), .line_last(s_ll), .frame_last(s_fl),
        .busy(s_busy), .done(s_done)
    );

    scan_addr_gen u_b (
        .clk(clk), .resetIn(b_rst), .start(b_start), .mode(b_mode),
        .abort(b_abort), .ready(b_ready), .valid(b_valid),
        .addr(b_addr), .row(b_row), .col(b_col),
        .line_first(b_lf), .line_last(b_ll), .frame_last(b_fl),
        .busy(b_busy), .done(b_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] mode;
        int         idx;
        logic [3:0] addr;
        logic       lf;
        logic       ll;
        logic       fl;
    } vec_t;

    vec_t tbl [48];

    int seqs [4][12] = '{
        '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11},
        '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11},
        '{0, 4, 1, 8, 5, 2, 9, 6, 3, 10, 7, 11},
        '{3, 7, 2, 11, 6, 1, 10, 5, 0, 9, 4, 8}
    };
    logic [11:0] fmask [4] = '{12'h111, 12'h249, 12'hA4B, 12'hA4B};
    logic [11:0] lmask [4] = '{12'h888, 12'h924, 12'hD25, 12'hD25};

    task automatic run_small(input int m, input bit bp);
        int k = 0;
        int cyc = 0;
        bit hold = 0;
        logic [15:0] saved = '0;
        logic [15:0] now;
        vec_t v;
        @(negedge clk);
        s_start = 1'b1;
        s_mode  = 2'(m);
        @(negedge clk);
        s_start = 1'b0;
        s_mode  = ~2'(m);
        chk($sformatf("m%0d start valid/busy", m),
            {s_valid, s_busy}, 2'b11);
        while (k < 12 && cyc < 200) begin
            now = {3'b0, s_valid, s_addr, s_row, s_col,
                   s_lf, s_ll, s_fl, s_busy};
            if (hold)
                chk($sformatf("m%0d hold k%0d", m, k), now, saved);
            s_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s_valid && s_ready) begin
                v = tbl[m*12 + k];
                chk($sformatf("m%0d beat%0d", m, k),
                    {s_addr, s_row, s_col, s_lf, s_ll, s_fl},
                    {v.addr, 2'(v.addr / 4), 2'(v.addr % 4),
                     v.lf, v.ll, v.fl});
                k++;
            end
            hold  = s_valid && !s_ready;
            saved = now;
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("m%0d beat count", m), 64'(k), 64'd12);
        chk($sformatf("m%0d done pulse", m),
            {s_done, s_valid, s_busy}, 3'b100);
        s_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("m%0d done clear", m), {63'b0, s_done}, 64'd0);
    endtask

    task automatic run_big(input bit inj);
        int k = 0;
        int cyc = 0;
        int err = 0;
        @(negedge clk);
        b_start = 1'b1;
        b_mode  = 2'd0;
        b_ready = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        while (k < 22500 && cyc < 30000) begin
            b_start = (inj && k == 3);
            b_mode  = (inj && k == 3) ? 2'd1 : 2'd0;
            if (!b_valid) begin
                err++;
            end else begin
                if (int'(b_addr) != k || int'(b_row) != k / 150 ||
                    int'(b_col) != k % 150 ||
                    b_lf != (k % 150 == 0) ||
                    b_ll != (k % 150 == 149) ||
                    b_fl != (k == 22499))
                    err++;
                if (k == 149)
                    chk("big line_last@149", {b_ll, b_fl}, 2'b10);
                if (k == 22499)
                    chk("big frame_last@22499", {b_ll, b_fl}, 2'b11);
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        b_start = 1'b0;
        b_mode  = 2'd0;
        chk("big beat errors", 64'(err), 64'd0);
        chk("big beat count", 64'(k), 64'd22500);
        chk("big done", {b_done, b_valid, b_busy}, 3'b100);
    endtask

    task automatic run_big_to(input int n);
        int k = 0;
        int cyc = 0;
        @(negedge clk);
        b_start = 1'b1;
        b_mode  = 2'd0;
        b_ready = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        while (k < n && cyc < 1000) begin
            if (b_valid)
                k++;
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("big at beat %0d", n),
            {b_valid, b_addr}, {1'b1, 15'(n)});
    endtask

    initial begin
        for (int m = 0; m < 4; m++)
            for (int i = 0; i < 12; i++)
                tbl[m*12 + i] = '{mode: 2'(m), idx: i,
                                  addr: 4'(seqs[m][i]),
                                  lf: fmask[m][i], ll: lmask[m][i],
                                  fl: (i == 11)};

        s_rst = 1'b1; s_start = 1'b0; s_abort = 1'b0;
        s_ready = 1'b1; s_mode = 2'd0;
        b_rst = 1'b1; b_start = 1'b0; b_abort = 1'b0;
        b_ready = 1'b1; b_mode = 2'd0;
        repeat (2) @(negedge clk);
        s_rst = 1'b0;
        b_rst = 1'b0;
        chk("small reset",
            {s_valid, s_addr, s_row, s_col, s_lf, s_ll, s_fl,
             s_busy, s_done}, 64'd0);
        chk("big reset",
            {b_valid, b_addr, b_row, b_col, b_lf, b_ll, b_fl,
             b_busy, b_done}, 64'd0);

        for (int m = 0; m < 4; m++)
            run_small(m, 1'b0);
        run_small(0, 1'b1);
        run_small(3, 1'b1);

        run_big(1'b1);

        run_big_to(5);
        b_abort = 1'b1;
        @(negedge clk);
        b_abort = 1'b0;
        chk("abort idle", {b_valid, b_busy, b_done}, 3'b000);
        @(negedge clk);
        chk("abort no done", {b_valid, b_done}, 2'b00);
        run_big(1'b0);

        run_big_to(7);
        b_rst = 1'b1;
        @(negedge clk);
        b_rst = 1'b0;
        chk("mid reset",
            {b_valid, b_addr, b_row, b_col, b_lf, b_ll, b_fl,
             b_busy, b_done}, 64'd0);
        run_big(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
